// File: rtl/fp_posit_seq_ctrl_pkg.sv
// Shared types and constants for the FP16 x posit multiplier sequencer.
package fp_posit_seq_ctrl_pkg;

   localparam int ACT_WIDTH = 16;
   localparam int MAX_PREC  = 8;
   localparam int PREC_W    = 4;
   localparam int MIN_PREC  = 2;
   localparam int DONE_TO   = 3;
   localparam int CNT_W     = $clog2(MAX_PREC);
   localparam int TO_W      = $clog2(DONE_TO);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONFIG,
      ST_SHIFT,
      ST_WAIT,
      ST_RESULT
   } state_e;

   // Posit widths below 2 or above the datapath width are meaningless to the multiplier.
   function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p);
      if (p < PREC_W'(MIN_PREC)) return PREC_W'(MIN_PREC);
      if (p > PREC_W'(MAX_PREC)) return PREC_W'(MAX_PREC);
      return p;
   endfunction

endpackage

// File: rtl/fp_posit_seq_ctrl_if.sv
// Config, operand, multiplier and result signals of the sequencer, bundled as one bus.
interface fp_posit_seq_ctrl_if;
   import fp_posit_seq_ctrl_pkg::*;

   logic                 cfg_valid;
   logic [PREC_W-1:0]    cfg_precision;
   logic                 cfg_ready;
   logic                 in_valid;
   logic [ACT_WIDTH-1:0] in_act;
   logic [MAX_PREC-1:0]  in_w;
   logic                 in_ready;
   logic                 mul_set;
   logic [PREC_W-1:0]    mul_precision;
   logic [ACT_WIDTH-1:0] mul_act;
   logic                 mul_w;
   logic                 mul_valid;
   logic                 mul_sign;
   logic                 mul_done;
   logic                 out_valid;
   logic                 out_sign;
   logic                 out_ready;
   logic                 busy;
   logic                 err;

   modport slave (
      input  cfg_valid, cfg_precision, in_valid, in_act, in_w, mul_sign, mul_done, out_ready,
      output cfg_ready, in_ready, mul_set, mul_precision, mul_act, mul_w, mul_valid,
             out_valid, out_sign, busy, err
   );

   modport master (
      output cfg_valid, cfg_precision, in_valid, in_act, in_w, mul_sign, mul_done, out_ready,
      input  cfg_ready, in_ready, mul_set, mul_precision, mul_act, mul_w, mul_valid,
             out_valid, out_sign, busy, err
   );

endinterface

// File: rtl/fp_posit_seq_ctrl_serializer.sv
// Holds one posit weight and presents it MSB-first, one bit per shift, from bit prec-1 down.
module fp_posit_seq_ctrl_serializer
   import fp_posit_seq_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic [MAX_PREC-1:0] w_i,
   input  logic [PREC_W-1:0]   prec_i,
   input  logic                shift_i,
   output logic                bit_o,
   output logic                last_o
);

   logic [MAX_PREC-1:0] w_q, w_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_d   = w_q;
      cnt_d = cnt_q;
      if (load_i) begin
         w_d   = w_i;
         cnt_d = CNT_W'(prec_i - PREC_W'(1));
      end else if (shift_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_o  = w_q[cnt_q];
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/fp_posit_seq_ctrl.sv
// Sequencer for the bit-serial FP16 x posit multiplier: config, serialise, await done, result.
module fp_posit_seq_ctrl
   import fp_posit_seq_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   fp_posit_seq_ctrl_if.slave  bus
);

   state_e               state_q, state_d;
   logic                 configured_q, configured_d;
   logic [PREC_W-1:0]    prec_q, prec_d;
   logic [ACT_WIDTH-1:0] act_q, act_d;
   logic                 sign_q, sign_d;
   logic                 err_q, err_d;
   logic [TO_W-1:0]      to_q, to_d;
   logic                 in_ready;
   logic                 accept;
   logic                 ser_bit;
   logic                 ser_last;

   // A pending config request in IDLE blocks operands; RESULT can hand straight to SHIFT.
   assign in_ready = ((state_q == ST_IDLE) && configured_q && !bus.cfg_valid) ||
                     ((state_q == ST_RESULT) && bus.out_ready && configured_q);
   assign accept   = bus.in_valid && in_ready;

   fp_posit_seq_ctrl_serializer u_ser (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .w_i     (bus.in_w),
      .prec_i  (prec_q),
      .shift_i (state_q == ST_SHIFT),
      .bit_o   (ser_bit),
      .last_o  (ser_last)
   );

   always_comb begin
      state_d      = state_q;
      configured_d = configured_q;
      prec_d       = prec_q;
      act_d        = act_q;
      sign_d       = sign_q;
      err_d        = err_q;
      to_d         = to_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_valid) begin
               prec_d  = clamp_prec(bus.cfg_precision);
               err_d   = 1'b0;
               state_d = ST_CONFIG;
            end else if (accept) begin
               act_d   = bus.in_act;
               state_d = ST_SHIFT;
            end
         end
         ST_CONFIG: begin
            configured_d = 1'b1;
            state_d      = ST_IDLE;
         end
         ST_SHIFT: begin
            to_d = '0;
            if (ser_last) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mul_done) begin
               sign_d  = bus.mul_sign;
               state_d = ST_RESULT;
            end else if (to_q == TO_W'(DONE_TO - 1)) begin
               err_d   = 1'b1;
               sign_d  = 1'b0;
               state_d = ST_RESULT;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         ST_RESULT: begin
            if (bus.out_ready) begin
               if (accept) begin
                  act_d   = bus.in_act;
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         configured_q <= 1'b0;
         prec_q       <= '0;
         act_q        <= '0;
         sign_q       <= 1'b0;
         err_q        <= 1'b0;
         to_q         <= '0;
      end else begin
         state_q      <= state_d;
         configured_q <= configured_d;
         prec_q       <= prec_d;
         act_q        <= act_d;
         sign_q       <= sign_d;
         err_q        <= err_d;
         to_q         <= to_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.cfg_ready     = (state_q == ST_IDLE);
   assign bus.mul_set       = (state_q == ST_CONFIG);
   assign bus.mul_precision = prec_q;
   assign bus.mul_act       = act_q;
   assign bus.mul_valid     = (state_q == ST_SHIFT);
   assign bus.mul_w         = (state_q == ST_SHIFT) && ser_bit;
   assign bus.out_valid     = (state_q == ST_RESULT);
   assign bus.out_sign      = sign_q;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.err           = err_q;

endmodule

// File: tb/tb_fp_posit_seq_ctrl.sv
// Directed bench for fp_posit_seq_ctrl with a multiplier stand-in and an operand-level model.
module tb_fp_posit_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   fp_posit_seq_ctrl_if bus();

   fp_posit_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic expire(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   function automatic int clamp_ref(input int p);
      return (p < 2) ? 2 : ((p > 8) ? 8 : p);
   endfunction

   // ---------------- operand-level model ----------------
   typedef struct {
      logic [15:0] act;
      logic [7:0]  w;
      int          prec;
   } op_t;

   typedef struct {
      logic sign;
      int   vis;
      bit   to;
   } res_t;

   op_t  sq[$];
   res_t rq[$];
   int   beat = 0;
   int   model_prec = 0;
   bit   set_pend = 0;
   bit   exp_err = 0;
   bit   done_en = 1;
   int   mv_count = 0;
   int   mv_first = -1;
   int   mv_last = -1;
   int   n_results = 0;

   always @(negedge clk) begin
      bit exp_ov;
      check("mul_valid", bus.mul_valid, sq.size() != 0);
      check("mul_set", bus.mul_set, set_pend);
      check("mul_precision", bus.mul_precision, model_prec);
      if (bus.mul_valid && sq.size() != 0) begin
         op_t h;
         int  idx;
         h   = sq[0];
         idx = h.prec - 1 - beat;
         check("mul_act", bus.mul_act, h.act);
         check("mul_w", bus.mul_w, h.w[idx]);
         beat++;
         mv_count++;
         if (mv_first < 0) mv_first = cyc;
         mv_last = cyc;
         if (beat == h.prec) begin
            res_t r;
            r.sign = done_en ? (h.act[15] ^ h.w[h.prec-1]) : 1'b0;
            r.vis  = done_en ? cyc + 2 : cyc + 4;
            r.to   = !done_en;
            rq.push_back(r);
            void'(sq.pop_front());
            beat = 0;
         end
      end
      exp_ov = (rq.size() != 0) && (cyc >= rq[0].vis);
      if (exp_ov && rq[0].to) exp_err = 1;
      check("out_valid", bus.out_valid, exp_ov);
      check("err", bus.err, exp_err);
      if (exp_ov) begin
         check("out_sign", bus.out_sign, rq[0].sign);
         if (bus.out_ready) begin
            void'(rq.pop_front());
            n_results++;
         end
      end
      set_pend = 0;
      if (bus.cfg_valid && bus.cfg_ready) begin
         model_prec = clamp_ref(int'(bus.cfg_precision));
         set_pend   = 1;
         exp_err    = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
         op_t o;
         o.act  = bus.in_act;
         o.w    = bus.in_w;
         o.prec = model_prec;
         sq.push_back(o);
      end
      if (rst) begin
         sq.delete();
         rq.delete();
         beat       = 0;
         model_prec = 0;
         set_pend   = 0;
         exp_err    = 0;
      end
   end

   // ---------------- multiplier stand-in: done one cycle after the last beat ----------------
   int   mb = 0;
   bit   fire = 0;
   logic first_w = 1'b0;
   logic fsign = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         mb   = 0;
         fire = 0;
      end else if (bus.mul_valid) begin
         if (mb == 0) first_w = bus.mul_w;
         mb++;
         if (mb >= int'(bus.mul_precision)) begin
            fire  = 1;
            fsign = bus.mul_act[15] ^ first_w;
            mb    = 0;
         end
      end
   end

   initial begin
      bus.mul_done = 1'b0;
      bus.mul_sign = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.mul_done = fire && done_en;
         bus.mul_sign = fsign;
         fire = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_cfg(input int p, input bit expect_held);
      bit ok = 0;
      bus.cfg_valid     = 1'b1;
      bus.cfg_precision = 4'(p);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0 && expect_held) check("cfg_ready_held_busy", bus.cfg_ready, 1'b0);
         if (bus.cfg_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.cfg_valid = 1'b0;
      if (!ok) expire("cfg_ready_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic send_op(input logic [15:0] a, input logic [7:0] w, output int acc);
      bus.in_valid = 1'b1;
      bus.in_act   = a;
      bus.in_w     = w;
      acc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            acc = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (acc < 0) expire("in_ready_wait");
   endtask

   task automatic run_op(input logic [15:0] a, input logic [7:0] w, output int beats,
                         output logic [7:0] bits, output int lat, output logic sgn);
      int acc;
      send_op(a, w, acc);
      beats = 0;
      bits  = '0;
      lat   = -1;
      sgn   = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.mul_valid) begin
            bits = {bits[6:0], bus.mul_w};
            beats++;
         end
         if (bus.out_valid) begin
            lat = cyc - acc;
            sgn = bus.out_sign;
            break;
         end
      end
      if (lat < 0) expire("out_valid_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sq.size() == 0 && rq.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) expire("drain_wait");
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   logic [15:0] b2b_act [4] = '{16'h3C00, 16'hBC00, 16'hC000, 16'h4200};
   logic [7:0]  b2b_w   [4] = '{8'h05, 8'h0A, 8'h0F, 8'h03};

   initial begin
      int          beats, lat, acc, base;
      logic [7:0]  bits;
      logic        sgn;
      bit          ok;

      bus.cfg_valid     = 1'b0;
      bus.cfg_precision = '0;
      bus.in_valid      = 1'b0;
      bus.in_act        = '0;
      bus.in_w          = '0;
      bus.out_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_mul_precision", bus.mul_precision, 4'd0);
      check("rst_mul_valid", bus.mul_valid, 1'b0);
      check("rst_mul_set", bus.mul_set, 1'b0);
      check("rst_mul_act", bus.mul_act, 16'h0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_cfg_ready", bus.cfg_ready, 1'b1);

      // 1: operands refused until a precision is programmed
      bus.in_valid = 1'b1;
      bus.in_act   = 16'h1234;
      bus.in_w     = 8'hAA;
      repeat (6) begin
         @(negedge clk);
         check("unconfigured_in_ready", bus.in_ready, 1'b0);
         check("unconfigured_busy", bus.busy, 1'b0);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;

      // 2: precision 8, single operands
      do_cfg(8, 0);
      check("cfg8_precision", bus.mul_precision, 4'd8);
      run_op(16'h3C00, 8'b0100_0000, beats, bits, lat, sgn);
      check("p8_beats", beats, 8);
      check("p8_bits", bits, 8'b0100_0000);
      check("p8_latency", lat, 10);
      check("p8_sign_pos", sgn, 1'b0);
      run_op(16'hBC00, 8'b0100_0000, beats, bits, lat, sgn);
      check("p8_latency_2", lat, 10);
      check("p8_sign_neg", sgn, 1'b1);

      // 3: clamping, and config held off while busy
      do_cfg(1, 0);
      check("cfg1_clamped", bus.mul_precision, 4'd2);
      run_op(16'h3C00, 8'b0000_0010, beats, bits, lat, sgn);
      check("p2_beats", beats, 2);
      check("p2_bits", bits, 8'h02);
      check("p2_latency", lat, 4);
      check("p2_sign", sgn, 1'b1);
      do_cfg(12, 0);
      check("cfg12_clamped", bus.mul_precision, 4'd8);
      run_op(16'h4000, 8'hC3, beats, bits, lat, sgn);
      check("p8c_beats", beats, 8);
      check("p8c_bits", bits, 8'hC3);
      send_op(16'h4000, 8'h81, acc);
      do_cfg(3, 1);
      check("cfg3_after_busy", bus.mul_precision, 4'd3);

      // 4: back-to-back with in_valid and out_ready held high
      do_cfg(4, 0);
      mv_count = 0;
      mv_first = -1;
      mv_last  = -1;
      base     = n_results;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.in_act = b2b_act[k];
         bus.in_w   = b2b_w[k];
         ok = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
               ok = 1;
               break;
            end
         end
         if (!ok) expire("b2b_in_ready_wait");
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      wait_drain();
      check("b2b_beats", mv_count, 16);
      check("b2b_span", mv_last - mv_first + 1, 22);
      check("b2b_results", n_results - base, 4);

      // 5: missing mul_done raises sticky err; new config clears it
      done_en = 0;
      bus.out_ready = 1'b0;
      send_op(16'h3C00, 8'h09, acc);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = cyc - acc;
            break;
         end
      end
      if (lat < 0) expire("timeout_out_valid_wait");
      check("timeout_latency", lat, 8);
      check("timeout_err", bus.err, 1'b1);
      check("timeout_sign", bus.out_sign, 1'b0);
      repeat (2) begin
         @(negedge clk);
         check("timeout_out_valid_held", bus.out_valid, 1'b1);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("timeout_idle_busy", bus.busy, 1'b0);
      check("timeout_err_sticky", bus.err, 1'b1);
      done_en = 1;
      do_cfg(4, 0);
      check("cfg_clears_err", bus.err, 1'b0);

      // 6: reset during the third serial beat
      do_cfg(8, 0);
      send_op(16'h3C00, 8'hFF, acc);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_beat3_valid", bus.mul_valid, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_mul_valid", bus.mul_valid, 1'b0);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_precision", bus.mul_precision, 4'd0);
      check("midrst_cfg_ready", bus.cfg_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_act   = 16'h3C00;
      bus.in_w     = 8'h55;
      repeat (3) begin
         @(negedge clk);
         check("midrst_unconfigured_in_ready", bus.in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;

      do_cfg(2, 0);
      run_op(16'h3C00, 8'h01, beats, bits, lat, sgn);
      check("recover_beats", beats, 2);
      check("recover_latency", lat, 4);
      check("recover_sign", sgn, 1'b0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
